// File: rtl/cnt_share_ctrl.sv
// cnt_share_ctrl: round-robin sequencer that shares one loadable up-counter
// between two requesters. The winner's start value is loaded, the counter
// is enabled until it reaches the limit latched at grant time, then a
// one-cycle done pulse is returned to the owner.
// Optional build macro CNT_SHARE_CTRL_TIMEOUT_EN adds a run-cycle watchdog
// that forces completion after TIMEOUT_CYCLES RUN cycles and flags it on
// the timeout output; without it timeout is tied low.
module cnt_share_ctrl #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] start0,
  input  logic [WIDTH-1:0] start1,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count,
  output logic             load,
  output logic             enable,
  output logic [WIDTH-1:0] data,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic             gnt0_nx, gnt1_nx;
  logic [WIDTH-1:0] data_nx;
  logic [WIDTH-1:0] limit_q, limit_nx;
  // last_q=1 means requester 1 was served last, so requester 0 wins a tie
  logic             last_q, last_nx;
  logic             owner_req;
  logic             at_limit;
  logic             expire;

`ifdef CNT_SHARE_CTRL_TIMEOUT_EN
  localparam int RC_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [RC_W-1:0] run_cnt, run_cnt_nx;
  logic            to_q, to_nx;

  // Watchdog: clear while loading, count RUN cycles, remember a forced finish
  always_comb begin
    run_cnt_nx = run_cnt;
    if (state == LOAD) begin
      run_cnt_nx = '0;
    end else if (state == RUN) begin
      run_cnt_nx = run_cnt + RC_W'(1);
    end
    to_nx = (state == RUN) && owner_req && expire && !at_limit;
  end

  // Watchdog registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
      to_q    <= 1'b0;
    end else begin
      run_cnt <= run_cnt_nx;
      to_q    <= to_nx;
    end
  end

  assign expire  = (run_cnt == RC_W'(TIMEOUT_CYCLES));
  assign timeout = (state == DONE) && to_q;
`else
  // No watchdog in this build; the parameter stays for a uniform interface
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Owner still requesting, terminal-count compare and decoded strobes
  always_comb begin
    owner_req = (gnt0 && req0) || (gnt1 && req1);
    at_limit  = (count == limit_q);
    load      = (state == LOAD);
    enable    = (state == RUN) && !at_limit && owner_req && !expire;
    done      = (state == DONE);
  end

  // Arbitration and sequencing: next state plus next grant/data/limit/pointer
  always_comb begin
    state_nx = state;
    gnt0_nx  = gnt0;
    gnt1_nx  = gnt1;
    data_nx  = data;
    limit_nx = limit_q;
    last_nx  = last_q;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_q)) begin
          gnt0_nx  = 1'b1;
          gnt1_nx  = 1'b0;
          data_nx  = start0;
          limit_nx = limit;
          state_nx = LOAD;
        end else if (req1) begin
          gnt0_nx  = 1'b0;
          gnt1_nx  = 1'b1;
          data_nx  = start1;
          limit_nx = limit;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (!owner_req) begin
          // Abort: release without done, still rotate priority
          gnt0_nx  = 1'b0;
          gnt1_nx  = 1'b0;
          last_nx  = gnt1;
          state_nx = IDLE;
        end else begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          gnt0_nx  = 1'b0;
          gnt1_nx  = 1'b0;
          last_nx  = gnt1;
          state_nx = IDLE;
        end else if (at_limit || expire) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        // Always pass through IDLE so a waiting requester is arbitrated fairly
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        last_nx  = gnt1;
        state_nx = IDLE;
      end
      default: begin
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, grants, load value, latched limit and round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      data    <= '0;
      limit_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state   <= state_nx;
      gnt0    <= gnt0_nx;
      gnt1    <= gnt1_nx;
      data    <= data_nx;
      limit_q <= limit_nx;
      last_q  <= last_nx;
    end
  end

endmodule
